// File: rtl/gpu_div_issuer_if.sv
// Request/result bus between triangle setup and the divider issuer.
// The master modport is the requester/consumer side; the slave modport is the issuer.
interface gpu_div_issuer_if #(
    parameter int TAG_W = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic signed [31:0]      req_num;
    logic signed [21:0]      req_den;
    logic        [TAG_W-1:0] req_tag;
    logic                    res_valid;
    logic                    res_ready;
    logic        [19:0]      res_quot;
    logic        [TAG_W-1:0] res_tag;
    logic                    res_dz;

    modport master (
        output req_valid, req_num, req_den, req_tag, res_ready,
        input  req_ready, res_valid, res_quot, res_tag, res_dz
    );

    modport slave (
        input  req_valid, req_num, req_den, req_tag, res_ready,
        output req_ready, res_valid, res_quot, res_tag, res_dz
    );
endinterface

// File: rtl/gpu_div_issuer.sv
// Issues tagged requests to the fixed-latency signed divider and queues quotients in a credit-guarded FIFO.
// Optional divide-by-zero saturation: define GPU_DIV_ZERO_SAT_EN.
module gpu_div_issuer #(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic               clock,
    input  logic               nRst,
    input  logic               flush,
    gpu_div_issuer_if.slave    bus,
    output logic signed [31:0] div_num,
    output logic signed [21:0] div_den,
    input  logic        [19:0] div_quot
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef GPU_DIV_ZERO_SAT_EN
    localparam int EW = 20 + TAG_W + 1;

    function automatic logic [19:0] sat_quot(input logic [19:0] q, input logic dz, input logic neg);
        if (!dz)
            return q;
        return neg ? 20'h80000 : 20'h7FFFF;
    endfunction
`else
    localparam int EW = 20 + TAG_W;
`endif

    logic             accept, pop, wr;
    logic [CW-1:0]    reserved, count;
    logic [PW-1:0]    wptr, rptr;
    logic             vld_p [0:LATENCY];
    logic [TAG_W-1:0] tag_p [0:LATENCY];
`ifdef GPU_DIV_ZERO_SAT_EN
    logic             dz_p  [0:LATENCY];
    logic             neg_p [0:LATENCY];
`endif
    logic [EW-1:0]    mem [0:FIFO_DEPTH-1];
    logic [EW-1:0]    wdata, head;

    assign bus.req_ready = nRst & ~flush & (reserved < DEPTH_C);
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.res_valid = (count != '0);
    assign pop           = bus.res_valid & bus.res_ready & ~flush;
    assign wr            = vld_p[LATENCY] & ~flush;

    // Stage 0: issue register, holds its operands between accepts
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            div_num <= '0;
            div_den <= '0;
        end else if (accept) begin
            div_num <= bus.req_num;
            div_den <= bus.req_den;
        end
    end

    // Stages 1..LATENCY: track line, stage LATENCY lines up with div_quot
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i <= LATENCY; i++)
                vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i <= LATENCY; i++)
                vld_p[i] <= vld_p[i-1] & ~flush;
        end
    end

    always_ff @(posedge clock) begin
        tag_p[0] <= bus.req_tag;
`ifdef GPU_DIV_ZERO_SAT_EN
        dz_p[0]  <= (bus.req_den == '0);
        neg_p[0] <= bus.req_num[31];
`endif
        for (int i = 1; i <= LATENCY; i++) begin
            tag_p[i] <= tag_p[i-1];
`ifdef GPU_DIV_ZERO_SAT_EN
            dz_p[i]  <= dz_p[i-1];
            neg_p[i] <= neg_p[i-1];
`endif
        end
    end

`ifdef GPU_DIV_ZERO_SAT_EN
    assign wdata = {sat_quot(div_quot, dz_p[LATENCY], neg_p[LATENCY]), tag_p[LATENCY], dz_p[LATENCY]};
`else
    assign wdata = {div_quot, tag_p[LATENCY]};
`endif

    // Capture stage: result FIFO and credit counter
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            reserved <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            reserved <= '0;
        end else begin
            if (wr)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({accept, pop})
                2'b10:   reserved <= reserved + CW'(1);
                2'b01:   reserved <= reserved - CW'(1);
                default: reserved <= reserved;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr)
            mem[wptr] <= wdata;
    end

    assign head         = mem[rptr];
    assign bus.res_quot = bus.res_valid ? head[EW-1 -: 20] : '0;
`ifdef GPU_DIV_ZERO_SAT_EN
    assign bus.res_tag  = bus.res_valid ? head[TAG_W:1] : '0;
    assign bus.res_dz   = bus.res_valid & head[0];
`else
    assign bus.res_tag  = bus.res_valid ? head[TAG_W-1:0] : '0;
    assign bus.res_dz   = 1'b0;
`endif
endmodule

// File: tb/tb_gpu_div_issuer.sv
// Scoreboard bench for gpu_div_issuer with a behavioural fixed-latency divider.
module tb_gpu_div_issuer;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int TW    = 4;

`ifdef GPU_DIV_ZERO_SAT_EN
    localparam logic [19:0] ZQ_POS = 20'h7FFFF;
    localparam logic [19:0] ZQ_NEG = 20'h80000;
    localparam logic        ZDZ    = 1'b1;
`else
    localparam logic [19:0] ZQ_POS = 20'h0ABCD;
    localparam logic [19:0] ZQ_NEG = 20'h0ABCD;
    localparam logic        ZDZ    = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               nRst;
    logic               flush;
    logic signed [31:0] div_num;
    logic signed [21:0] div_den;
    logic        [19:0] div_quot;

    gpu_div_issuer_if #(.TAG_W(TW)) bus ();

    gpu_div_issuer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clock    (clock),
        .nRst     (nRst),
        .flush    (flush),
        .bus      (bus.slave),
        .div_num  (div_num),
        .div_den  (div_den),
        .div_quot (div_quot)
    );

    always #5 clock = ~clock;

    // Divider model: truncating signed divide, constant pattern on divide-by-zero
    logic [19:0] dpipe [0:LAT-1];
    function automatic logic [19:0] ddiv(input logic signed [31:0] n, input logic signed [21:0] d);
        logic signed [31:0] q;
        if (d == 0)
            return 20'h0ABCD;
        q = n / d;
        return q[19:0];
    endfunction

    always @(posedge clock) begin
        dpipe[0] <= ddiv(div_num, div_den);
        for (int i = 1; i < LAT; i++)
            dpipe[i] <= dpipe[i-1];
    end
    assign div_quot = dpipe[LAT-1];

    typedef struct packed {
        logic [19:0]    q;
        logic [TW-1:0]  t;
        logic           dz;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every popped head against the scoreboard
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (nRst && bus.res_valid && bus.res_ready && !flush) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_result: got quot %0h tag %0h, expected none", bus.res_quot, bus.res_tag);
            end else begin
                e = sb.pop_front();
                chk("res_quot", 32'(bus.res_quot), 32'(e.q));
                chk("res_tag",  32'(bus.res_tag),  32'(e.t));
                chk("res_dz",   32'(bus.res_dz),   32'(e.dz));
            end
        end
    end

    task automatic send(input logic signed [31:0] n, input logic signed [21:0] d, input logic [TW-1:0] t,
                        input logic [19:0] q, input logic dz, output int acc_cyc);
        bus.req_valid = 1'b1;
        bus.req_num   = n;
        bus.req_den   = d;
        bus.req_tag   = t;
        #1;
        for (int k = 0; k < 40 && !bus.req_ready; k++) begin
            @(negedge clock);
            #1;
        end
        if (!bus.req_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
            acc_cyc = -1;
        end else begin
            sb.push_back('{q: q, t: t, dz: dz});
            acc_cyc = cyc;
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_latency(input string name, input int acc_cyc);
        int k = 0;
        #1;
        while (!bus.res_valid && k < 30) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk(name, 32'(cyc - acc_cyc), 32'd7);
    endtask

    task automatic drain(input string name);
        int k = 0;
        bus.res_ready = 1'b1;
        #1;
        while ((sb.size() != 0 || bus.res_valid) && k < 60) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc, first, nxt, drops, seen;
        nRst          = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_num   = '0;
        bus.req_den   = '0;
        bus.req_tag   = '0;
        bus.res_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_res_quot",  32'(bus.res_quot),  0);
        chk("rst_div_num",   div_num,            0);
        @(negedge clock);
        nRst = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus.req_ready), 1);

        // Single op with latency and pop
        @(negedge clock);
        send(32'sd100, 22'sd7, 4'd3, 20'd14, 1'b0, acc);
        wait_latency("single_latency", acc);
        chk("single_head_quot", 32'(bus.res_quot), 32'd14);
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.res_ready = 1'b0;
        #1;
        chk("single_popped", 32'(bus.res_valid), 0);

        // Signed quotients, truncation toward zero
        @(negedge clock);
        bus.res_ready = 1'b1;
        send(-32'sd1000, 22'sd33,  4'd5, 20'hFFFE2, 1'b0, acc);
        send(32'sd1000,  -22'sd33, 4'd6, 20'hFFFE2, 1'b0, acc);
        send(-32'sd7,    22'sd2,   4'd7, 20'hFFFFD, 1'b0, acc);
        send(32'sd123456, 22'sd1,  4'd8, 20'h1E240, 1'b0, acc);
        drain("signed_drain");

        // Back-pressure: credits stop issue at FIFO_DEPTH
        @(negedge clock);
        bus.res_ready = 1'b0;
        nxt = 0;
        for (int a = 0; a < 12; a++) begin
            bus.req_valid = 1'b1;
            bus.req_num   = 32'(100 + 7 * nxt);
            bus.req_den   = 22'sd7;
            bus.req_tag   = TW'(nxt);
            #1;
            if (bus.req_ready) begin
                sb.push_back('{q: 20'(14 + nxt), t: TW'(nxt), dz: 1'b0});
                nxt++;
            end
            @(negedge clock);
        end
        #1;
        chk("bp_accepts",    32'(nxt), 32'd8);
        chk("bp_ready_low",  32'(bus.req_ready), 0);
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.res_ready = 1'b0;
        #1;
        chk("bp_ready_after_pop", 32'(bus.req_ready), 1);
        if (bus.req_ready)
            sb.push_back('{q: 20'(14 + nxt), t: TW'(nxt), dz: 1'b0});
        @(negedge clock);
        bus.req_valid = 1'b0;
        drain("bp_drain");

        // Streaming at full rate
        @(negedge clock);
        bus.res_ready = 1'b1;
        pop_cyc.delete();
        drops = 0;
        first = 0;
        for (int i = 0; i < 20; i++) begin
            bus.req_valid = 1'b1;
            bus.req_num   = 32'(21 * i);
            bus.req_den   = 22'sd3;
            bus.req_tag   = TW'(i);
            #1;
            if (!bus.req_ready)
                drops++;
            else begin
                sb.push_back('{q: 20'(7 * i), t: TW'(i), dz: 1'b0});
                if (i == 0)
                    first = cyc;
            end
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        drain("stream_drain");
        chk("stream_ready_drops", 32'(drops), 0);
        chk("stream_count", 32'(pop_cyc.size()), 32'd20);
        if (pop_cyc.size() == 20) begin
            chk("stream_first_result", 32'(pop_cyc[0] - first), 32'd7);
            chk("stream_last_result",  32'(pop_cyc[19] - first), 32'd26);
        end

        // Flush with 2 results queued and 3 in flight
        @(negedge clock);
        bus.res_ready = 1'b0;
        first = cyc;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_num   = 32'(50 + i);
            bus.req_den   = 22'sd1;
            bus.req_tag   = TW'(9 + i);
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        while (cyc < first + 8)
            @(negedge clock);
        #1;
        chk("flush_pre_valid", 32'(bus.res_valid), 1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        chk("flush_res_valid", 32'(bus.res_valid), 0);
        chk("flush_req_ready", 32'(bus.req_ready), 1);
        bus.res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            #1;
            if (bus.res_valid)
                seen++;
        end
        chk("flush_no_result", 32'(seen), 0);
        @(negedge clock);
        send(32'sd200, 22'sd8, 4'd2, 20'd25, 1'b0, acc);
        wait_latency("flush_new_latency", acc);
        drain("flush_drain");

        // Divide by zero
        @(negedge clock);
        send(32'sd5,  22'sd0,  4'd1, ZQ_POS,    ZDZ,  acc);
        send(-32'sd5, 22'sd0,  4'd2, ZQ_NEG,    ZDZ,  acc);
        send(32'sd50, -22'sd7, 4'd3, 20'hFFFF9, 1'b0, acc);
        drain("dz_drain");

        // Asynchronous reset mid-stream
        @(negedge clock);
        bus.res_ready = 1'b0;
        first = cyc;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req_num   = 32'(300 + 3 * i);
            bus.req_den   = 22'sd3;
            bus.req_tag   = TW'(4 + i);
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        sb.delete();
        while (cyc < first + 8)
            @(negedge clock);
        #1;
        chk("mid_pre_valid", 32'(bus.res_valid), 1);
        #2;
        nRst = 1'b0;
        #1;
        chk("mid_req_ready", 32'(bus.req_ready), 0);
        chk("mid_res_valid", 32'(bus.res_valid), 0);
        chk("mid_res_quot",  32'(bus.res_quot),  0);
        chk("mid_res_tag",   32'(bus.res_tag),   0);
        chk("mid_res_dz",    32'(bus.res_dz),    0);
        chk("mid_div_num",   div_num,            0);
        chk("mid_div_den",   32'(div_den),       0);
        @(negedge clock);
        @(negedge clock);
        nRst = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(bus.req_ready), 1);
        @(negedge clock);
        bus.res_ready = 1'b1;
        send(32'sd77, -22'sd7, 4'd9, 20'hFFFF5, 1'b0, acc);
        wait_latency("mid_new_latency", acc);
        drain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
